// File: rtl/muu_value_serializer_if.sv
// Handshake bundle for muu_value_serializer: command, value stream and output channels.
// The serializer sits on the slave modport; the surrounding pipeline drives the master side.
interface muu_value_serializer_if #(
    parameter int META_WIDTH   = 96,
    parameter int MEMORY_WIDTH = 512,
    parameter int OUT_WIDTH    = 64,
    parameter int LEN_WIDTH    = 16,
    parameter int USER_BITS    = 3
);
    logic [META_WIDTH-1:0]           cmd_meta;
    logic [LEN_WIDTH-1:0]            cmd_len;
    logic [7:0]                      cmd_status;
    logic [USER_BITS-1:0]            cmd_user;
    logic                            cmd_drop;
    logic                            cmd_valid;
    logic                            cmd_ready;

    logic [MEMORY_WIDTH-1:0]         value_data;
    logic                            value_valid;
    logic                            value_ready;

    logic [META_WIDTH+OUT_WIDTH-1:0] output_data;
    logic [7:0]                      output_user;
    logic                            output_valid;
    logic                            output_ready;
    logic                            output_last;

    modport master (
        output cmd_meta, cmd_len, cmd_status, cmd_user, cmd_drop, cmd_valid,
        output value_data, value_valid, output_ready,
        input  cmd_ready, value_ready, output_data, output_user, output_valid, output_last
    );

    modport slave (
        input  cmd_meta, cmd_len, cmd_status, cmd_user, cmd_drop, cmd_valid,
        input  value_data, value_valid, output_ready,
        output cmd_ready, value_ready, output_data, output_user, output_valid, output_last
    );
endinterface

// File: rtl/muu_value_serializer.sv
// Value-get response serializer: header word, then the value sliced from wide memory words
// into OUT_WIDTH lanes, with forced packet boundaries and a header-only drop path.
module muu_value_serializer #(
    parameter int META_WIDTH          = 96,
    parameter int MEMORY_WIDTH        = 512,
    parameter int OUT_WIDTH           = 64,
    parameter int LEN_WIDTH           = 16,
    parameter int USER_BITS           = 3,
    parameter int MAX_WORDS_IN_PACKET = 160
) (
    input  logic                   clk,
    input  logic                   rst_n,
    muu_value_serializer_if.slave  bus,
    output logic [31:0]            stat_responses
);
    localparam int B        = OUT_WIDTH / 8;
    localparam int M        = MEMORY_WIDTH / 8;
    localparam int RATIO    = MEMORY_WIDTH / OUT_WIDTH;
    localparam int CNT_W    = LEN_WIDTH + 1;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PKT_W    = (MAX_WORDS_IN_PACKET > 1) ? $clog2(MAX_WORDS_IN_PACKET) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATIO - 1);
    localparam logic [PKT_W-1:0] PKT_LAST  =
        PKT_W'((MAX_WORDS_IN_PACKET > 0) ? MAX_WORDS_IN_PACKET - 1 : 0);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_VALUE, S_DROP} state_t;

    state_t                 state, state_n;
    logic [META_WIDTH-1:0]  meta_q;
    logic [USER_BITS-1:0]   user_q;
    logic                   drop_q;
    logic                   len_zero_q;
    logic [CNT_W-1:0]       out_words_q;
    logic [CNT_W-1:0]       mem_words_q;
    logic [OUT_WIDTH-1:0]   hdr_q;
    logic [CNT_W-1:0]       remaining;
    logic [IDX_W-1:0]       idx;
    logic [PKT_W-1:0]       pkt_cnt;

    logic [CNT_W-1:0]       len_ext, cmd_out_words, cmd_mem_words;
    logic [OUT_WIDTH-1:0]   hdr_word;
    logic [OUT_WIDTH-1:0]   lane;
    logic                   split;
    logic                   cmd_fire, out_fire, val_fire;
    logic                   resp_done;

    // Word counts are rounded up, so a partial trailing word/memory word still counts.
    assign len_ext       = CNT_W'(bus.cmd_len);
    assign cmd_out_words = (len_ext + CNT_W'(B - 1)) >> $clog2(B);
    assign cmd_mem_words = (len_ext + CNT_W'(M - 1)) >> $clog2(M);

    always_comb begin
        hdr_word        = '0;
        hdr_word[15:0]  = 16'hFFFF;
        hdr_word[23:16] = bus.cmd_status;
        hdr_word[47:32] = bus.cmd_drop ? 16'h0000 : 16'(bus.cmd_len);
    end

    assign lane     = bus.value_data[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
    assign split    = (MAX_WORDS_IN_PACKET != 0) && (pkt_cnt == PKT_LAST);
    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign out_fire = bus.output_valid && bus.output_ready;
    assign val_fire = bus.value_valid && bus.value_ready;

    // NOTE: every output of this block gets a default before the case; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n          = state;
        bus.cmd_ready    = 1'b0;
        bus.value_ready  = 1'b0;
        bus.output_valid = 1'b0;
        bus.output_last  = 1'b0;
        bus.output_data  = '0;
        bus.output_user  = '0;
        resp_done        = 1'b0;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) state_n = S_HEADER;
            end
            S_HEADER: begin
                bus.output_valid = 1'b1;
                bus.output_data  = {meta_q, hdr_q};
                bus.output_user  = 8'(user_q);
                bus.output_last  = len_zero_q || drop_q || split;
                if (bus.output_ready) begin
                    if (len_zero_q) begin
                        state_n   = S_IDLE;
                        resp_done = 1'b1;
                    end else if (drop_q) begin
                        state_n = S_DROP;
                    end else begin
                        state_n = S_VALUE;
                    end
                end
            end
            S_VALUE: begin
                // Zero-latency pass-through: the upstream holds value_data until value_ready.
                bus.output_valid = bus.value_valid;
                bus.output_data  = {meta_q, lane};
                bus.output_user  = 8'(user_q);
                bus.output_last  = (remaining == ONE) || split;
                if (bus.value_valid && bus.output_ready) begin
                    bus.value_ready = (idx == LAST_LANE) || (remaining == ONE);
                    if (remaining == ONE) begin
                        state_n   = S_IDLE;
                        resp_done = 1'b1;
                    end
                end
            end
            S_DROP: begin
                bus.value_ready = 1'b1;
                if (bus.value_valid && remaining == ONE) begin
                    state_n   = S_IDLE;
                    resp_done = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            remaining      <= '0;
            idx            <= '0;
            pkt_cnt        <= '0;
            stat_responses <= '0;
        end else begin
            state <= state_n;
            if (out_fire) pkt_cnt <= bus.output_last ? '0 : pkt_cnt + 1'b1;
            if (resp_done) stat_responses <= stat_responses + 32'd1;
            case (state)
                S_HEADER: if (out_fire) begin
                    remaining <= drop_q ? mem_words_q : out_words_q;
                    idx       <= '0;
                end
                S_VALUE: if (out_fire) begin
                    remaining <= remaining - ONE;
                    idx       <= (idx == LAST_LANE) ? '0 : idx + IDX_W'(1);
                end
                S_DROP: if (val_fire) remaining <= remaining - ONE;
                default: ;
            endcase
        end
    end

    // NOTE: the latched command fields are plain datapath registers without reset; they are
    // only observed after a command handshake has loaded them.
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            meta_q      <= bus.cmd_meta;
            user_q      <= bus.cmd_user;
            drop_q      <= bus.cmd_drop;
            len_zero_q  <= (bus.cmd_len == '0);
            out_words_q <= cmd_out_words;
            mem_words_q <= cmd_mem_words;
            hdr_q       <= hdr_word;
        end
    end
endmodule

// File: tb/tb_muu_value_serializer.sv
// Randomized bench for muu_value_serializer: a default instance and a MAX_WORDS_IN_PACKET=4
// instance run in lockstep against an expected-word list built from the response rules.
module tb_muu_value_serializer;
    localparam int META_W = 96;
    localparam int MEM_W  = 512;
    localparam int OUT_W  = 64;
    localparam int LEN_W  = 16;
    localparam int USER_B = 3;
    localparam int MAX_A  = 160;
    localparam int MAX_S  = 4;
    localparam int RATIO  = MEM_W / OUT_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stat_a, stat_s;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_stat = '0;
    int          pc_a = 0;
    int          pc_s = 0;

    always #5 clk = ~clk;

    muu_value_serializer_if #(.META_WIDTH(META_W), .MEMORY_WIDTH(MEM_W), .OUT_WIDTH(OUT_W),
        .LEN_WIDTH(LEN_W), .USER_BITS(USER_B)) ifa ();
    muu_value_serializer_if #(.META_WIDTH(META_W), .MEMORY_WIDTH(MEM_W), .OUT_WIDTH(OUT_W),
        .LEN_WIDTH(LEN_W), .USER_BITS(USER_B)) ifs ();

    assign ifs.cmd_meta     = ifa.cmd_meta;
    assign ifs.cmd_len      = ifa.cmd_len;
    assign ifs.cmd_status   = ifa.cmd_status;
    assign ifs.cmd_user     = ifa.cmd_user;
    assign ifs.cmd_drop     = ifa.cmd_drop;
    assign ifs.cmd_valid    = ifa.cmd_valid;
    assign ifs.value_data   = ifa.value_data;
    assign ifs.value_valid  = ifa.value_valid;
    assign ifs.output_ready = ifa.output_ready;

    muu_value_serializer #(.META_WIDTH(META_W), .MEMORY_WIDTH(MEM_W), .OUT_WIDTH(OUT_W),
        .LEN_WIDTH(LEN_W), .USER_BITS(USER_B), .MAX_WORDS_IN_PACKET(MAX_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .stat_responses(stat_a));

    muu_value_serializer #(.META_WIDTH(META_W), .MEMORY_WIDTH(MEM_W), .OUT_WIDTH(OUT_W),
        .LEN_WIDTH(LEN_W), .USER_BITS(USER_B), .MAX_WORDS_IN_PACKET(MAX_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(ifs), .stat_responses(stat_s));

    task automatic run_resp(input int len, input logic [7:0] status, input logic [USER_B-1:0] user,
                            input logic drop, input bit bp, input string name);
        logic [MEM_W-1:0]       mem[$];
        logic [META_W+OUT_W-1:0] exp_data[$];
        bit                     exp_la[$];
        bit                     exp_ls[$];
        logic [META_W-1:0]      meta;
        logic [MEM_W-1:0]       w;
        logic [OUT_W-1:0]       hdr;
        int out_words, mem_words, n_exp, k, vptr, done_c, want_c;
        bit fin, la, ls, done;

        out_words = (len + 7) / 8;
        mem_words = (len + 63) / 64;
        for (int i = 0; i < META_W / 32; i++) meta[i*32 +: 32] = $urandom;
        for (int m = 0; m < mem_words; m++) begin
            for (int j = 0; j < MEM_W / 32; j++) w[j*32 +: 32] = $urandom;
            mem.push_back(w);
        end
        hdr = '0;
        hdr[15:0]  = 16'hFFFF;
        hdr[23:16] = status;
        hdr[47:32] = drop ? 16'h0000 : 16'(len);
        exp_data.push_back({meta, hdr});
        if (!drop) begin
            for (int i = 0; i < out_words; i++) begin
                w = mem[i / RATIO];
                exp_data.push_back({meta, w[(i % RATIO)*OUT_W +: OUT_W]});
            end
        end
        n_exp = exp_data.size();
        for (int i = 0; i < n_exp; i++) begin
            fin  = (i == n_exp - 1);
            la   = fin || (pc_a == MAX_A - 1);
            ls   = fin || (pc_s == MAX_S - 1);
            pc_a = la ? 0 : pc_a + 1;
            pc_s = ls ? 0 : pc_s + 1;
            exp_la.push_back(la);
            exp_ls.push_back(ls);
        end

        @(posedge clk); #1;
        ifa.cmd_meta     = meta;
        ifa.cmd_len      = 16'(len);
        ifa.cmd_status   = status;
        ifa.cmd_user     = user;
        ifa.cmd_drop     = drop;
        ifa.cmd_valid    = 1'b1;
        ifa.value_valid  = 1'b0;
        ifa.output_ready = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (ifa.cmd_ready === 1'b1) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s cmd_accept: cmd_ready=%b, required 1", name, ifa.cmd_ready);
            ifa.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0;

        k = 0; vptr = 0; done = 1'b0; done_c = 0;
        for (int c = 1; c <= 4000 && !done; c++) begin
            ifa.output_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ifa.value_valid  = (vptr < mem_words) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            ifa.value_data   = (vptr < mem_words) ? mem[vptr] : '0;
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if (ifa.output_valid !== 1'b1 || ifa.value_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s header_cycle: valid=%b value_ready=%b, required 1/0",
                             name, ifa.output_valid, ifa.value_ready);
                end
            end
            if (ifa.output_valid === 1'b1 && ifa.output_ready) begin
                n_cmp++;
                if (k >= n_exp) begin
                    n_fail++;
                    $display("FAIL %s extra_word: got %h, required none", name, ifa.output_data);
                end else begin
                    if (ifa.output_data !== exp_data[k] || ifa.output_user !== 8'(user) ||
                        ifa.output_last !== exp_la[k]) begin
                        n_fail++;
                        $display("FAIL %s word%0d: got %h user %h last %b, required %h user %h last %b",
                                 name, k, ifa.output_data, ifa.output_user, ifa.output_last,
                                 exp_data[k], 8'(user), exp_la[k]);
                    end
                    n_cmp++;
                    if (ifs.output_valid !== 1'b1 || ifs.output_data !== exp_data[k] ||
                        ifs.output_last !== exp_ls[k]) begin
                        n_fail++;
                        $display("FAIL %s split_word%0d: got v%b %h last %b, required v1 %h last %b",
                                 name, k, ifs.output_valid, ifs.output_data, ifs.output_last,
                                 exp_data[k], exp_ls[k]);
                    end
                    k++;
                end
            end
            if (ifa.value_valid && ifa.value_ready === 1'b1) vptr++;
            if (k == n_exp && ifa.cmd_ready === 1'b1) begin
                done   = 1'b1;
                done_c = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        ifa.value_valid = 1'b0;

        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: words %0d, required %0d", name, k, n_exp);
            return;
        end
        n_cmp++;
        if (vptr != mem_words) begin
            n_fail++;
            $display("FAIL %s mem_consumed: got %0d, required %0d", name, vptr, mem_words);
        end
        exp_stat++;
        n_cmp++;
        if (stat_a !== exp_stat || stat_s !== exp_stat) begin
            n_fail++;
            $display("FAIL %s stat_responses: got %0d/%0d, required %0d", name, stat_a, stat_s, exp_stat);
        end
        if (!bp) begin
            want_c = (drop && len > 0) ? mem_words + 2 : n_exp + 1;
            n_cmp++;
            if (done_c != want_c) begin
                n_fail++;
                $display("FAIL %s cycles: got %0d, required %0d", name, done_c, want_c);
            end
        end
    endtask

    task automatic test_reset();
        ifa.cmd_valid = 1'b0; ifa.cmd_meta = '0; ifa.cmd_len = '0; ifa.cmd_status = '0;
        ifa.cmd_user = '0; ifa.cmd_drop = 1'b0; ifa.value_data = '0; ifa.value_valid = 1'b0;
        ifa.output_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ifa.cmd_ready !== 1'b0 || ifa.output_valid !== 1'b0 || ifa.output_last !== 1'b0 ||
            ifa.value_ready !== 1'b0 || ifa.output_data !== '0 || ifa.output_user !== '0 ||
            stat_a !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy %b v %b l %b vr %b stat %0d, required all 0",
                     ifa.cmd_ready, ifa.output_valid, ifa.output_last, ifa.value_ready, stat_a);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ifa.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready %b, required 1", ifa.cmd_ready);
        end
    endtask

    task automatic test_short();
        run_resp(20, 8'h01, 3'($urandom), 1'b0, 1'b0, "short");
    endtask

    task automatic test_boundaries();
        run_resp(64, 8'($urandom), 3'($urandom), 1'b0, 1'b0, "len64");
        run_resp(72, 8'($urandom), 3'($urandom), 1'b0, 1'b0, "len72");
    endtask

    task automatic test_drop();
        run_resp(130, 8'($urandom), 3'($urandom), 1'b1, 1'b0, "drop");
    endtask

    task automatic test_split();
        run_resp(64, 8'h02, 3'($urandom), 1'b0, 1'b0, "split4");
        run_resp(1600, 8'h03, 3'($urandom), 1'b0, 1'b0, "split160");
    endtask

    task automatic test_backpressure();
        run_resp(200, 8'h04, 3'($urandom), 1'b0, 1'b0, "free200");
        run_resp(200, 8'h04, 3'($urandom), 1'b0, 1'b1, "bp200");
    endtask

    task automatic test_zero_len();
        run_resp(0, 8'h05, 3'($urandom), 1'b0, 1'b0, "zero");
        run_resp(0, 8'h06, 3'($urandom), 1'b1, 1'b0, "zero_drop");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            run_resp($urandom_range(0, 400), 8'($urandom), 3'($urandom),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "random");
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [MEM_W-1:0] w;
        for (int j = 0; j < MEM_W / 32; j++) w[j*32 +: 32] = $urandom;
        @(posedge clk); #1;
        ifa.cmd_len = 16'd200; ifa.cmd_drop = 1'b0; ifa.cmd_valid = 1'b1;
        ifa.output_ready = 1'b1; ifa.value_valid = 1'b1; ifa.value_data = w;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (ifa.cmd_ready === 1'b1) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (ifa.output_valid !== 1'b1 || ifa.output_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_value: valid %b last %b, required 1/0", ifa.output_valid, ifa.output_last);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        ifa.value_valid = 1'b0;
        n_cmp++;
        if (ifa.cmd_ready !== 1'b0 || ifa.output_valid !== 1'b0 || ifa.output_last !== 1'b0 ||
            ifa.value_ready !== 1'b0 || ifa.output_data !== '0 || ifa.output_user !== '0 ||
            stat_a !== '0 || ifs.output_valid !== 1'b0 || stat_s !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy %b v %b l %b vr %b data %h stat %0d, required all 0",
                     ifa.cmd_ready, ifa.output_valid, ifa.output_last, ifa.value_ready,
                     ifa.output_data, stat_a);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ifa.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: cmd_ready %b, required 1", ifa.cmd_ready);
        end
        exp_stat = '0;
        pc_a = 0;
        pc_s = 0;
        run_resp(24, 8'h07, 3'($urandom), 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_short();
        test_boundaries();
        test_drop();
        test_split();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
